// File: rtl/ysyx_040729_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_040729_pkg
// Shared definitions for the instruction-fetch responder:
//   - state_e          : responder FSM states (IDLE, REQ, DRAIN)
//   - LINE_OFF_W       : byte-offset bits inside one 64-bit buffered line
//   - HALF_SEL_BIT     : address bit that picks the upper/lower instruction
//   - ERR_INST_DEFAULT : word returned with fetch_err (decodes as illegal)
// ---------------------------------------------------------------------------
package ysyx_040729_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // serving hits / errors, launching misses
        REQ   = 2'd1,   // miss outstanding, result will fill the line buffer
        DRAIN = 2'd2    // request abandoned, waiting out its ack
    } state_e;

    localparam int unsigned LINE_OFF_W   = 3;
    localparam int unsigned HALF_SEL_BIT = 2;

    localparam logic [31:0] ERR_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ysyx_040729_line_buffer.sv
// ---------------------------------------------------------------------------
// ysyx_040729_line_buffer
// Single-line fetch buffer: one valid bit, one full-width line tag and one
// 64-bit line of two instructions. Looks up a tag combinationally and returns
// the selected instruction half.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   inval_i        drop the buffered line this edge; also masks hit_o now
//   fill_en_i      write fill_tag_i / fill_data_i and mark the line valid
//   fill_tag_i     line tag to store
//   fill_data_i    line data, instruction @+0 in [31:0], @+4 in [63:32]
//   lookup_tag_i   tag of the current fetch address
//   half_sel_i     address bit 2 of the current fetch
//   hit_o          buffered line matches lookup_tag_i
//   rdata_o        selected instruction of the buffered line
// ---------------------------------------------------------------------------
module ysyx_040729_line_buffer
    import ysyx_040729_pkg::*;
#(
    parameter int unsigned TAG_W      = 61,
    parameter int unsigned LINE_WIDTH = 64,
    parameter int unsigned INST_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inval_i,
    input  logic                  fill_en_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    input  logic [LINE_WIDTH-1:0] fill_data_i,
    input  logic [TAG_W-1:0]      lookup_tag_i,
    input  logic                  half_sel_i,
    output logic                  hit_o,
    output logic [INST_WIDTH-1:0] rdata_o
);

    logic                  valid_q;
    logic [TAG_W-1:0]      tag_q;
    logic [LINE_WIDTH-1:0] data_q;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (fill_en_i) begin
            valid_q <= 1'b1;
        end
    end

    // NOTE: tag and data have no reset; valid_q qualifies every use of them,
    // so clearing valid_q alone is enough and keeps the storage plain flops.
    always_ff @(posedge clock) begin
        if (fill_en_i && !inval_i) begin
            tag_q  <= fill_tag_i;
            data_q <= fill_data_i;
        end
    end

    // An invalidate in the same cycle forces a miss before the flop clears.
    assign hit_o   = valid_q && (tag_q == lookup_tag_i) && !inval_i;
    assign rdata_o = half_sel_i ? data_q[LINE_WIDTH-1:INST_WIDTH]
                                : data_q[INST_WIDTH-1:0];

endmodule

// File: rtl/ysyx_040729_imem_responder.sv
// ---------------------------------------------------------------------------
// ysyx_040729_imem_responder
// Responder end of the core's instruction-fetch port. Hits in the one-line
// buffer answer in the same cycle; misses issue one req/ack line read to the
// backing instruction memory, fill the buffer and answer the cycle after.
// Misaligned PCs and memory timeouts answer with fetch_err and ERR_INST.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   if_valid       core fetch request
//   if_addr        fetch PC, stable until handshake
//   if_ready       instruction (or error) valid this cycle
//   if_data_read   instruction for if_addr while if_ready
//   fetch_err      qualifies if_ready: misaligned PC or memory timeout
//   flush          invalidate the line buffer
//   mem_req        backing read request, held until mem_ack
//   mem_addr       line-aligned read address, stable while mem_req
//   mem_ack        one-cycle pulse, mem_rdata valid
//   mem_rdata      64-bit line, little-endian instruction order
// ---------------------------------------------------------------------------
module ysyx_040729_imem_responder
    import ysyx_040729_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           INST_WIDTH = 32,
    parameter int unsigned           LINE_WIDTH = 64,
    parameter int unsigned           TIMEOUT    = 256,
    parameter logic [INST_WIDTH-1:0] ERR_INST   = ERR_INST_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [INST_WIDTH-1:0] if_data_read,
    output logic                  fetch_err,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [LINE_WIDTH-1:0] mem_rdata
);

    localparam int unsigned     TAG_W    = ADDR_WIDTH - LINE_OFF_W;
    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TAG_W-1:0] req_tag_q, req_tag_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [TAG_W-1:0]      if_tag;
    logic                  misaligned;
    logic                  timeout;
    logic                  buf_hit;
    logic [INST_WIDTH-1:0] buf_rdata;
    logic                  fill_en;
    logic                  buf_inval;
    logic                  rsp_ready;
    logic                  rsp_err;
    logic [INST_WIDTH-1:0] rsp_data;

    assign if_tag     = if_addr[ADDR_WIDTH-1:LINE_OFF_W];
    assign misaligned = |if_addr[1:0];

    // Last allowed wait cycle with no ack: give up on this request.
    assign timeout = (state_q == REQ) && (wait_cnt_q == CNT_LAST) && !mem_ack;

    // A timed-out miss leaves nothing trustworthy to hit on afterwards.
    assign buf_inval = flush || timeout;

    ysyx_040729_line_buffer #(
        .TAG_W      (TAG_W),
        .LINE_WIDTH (LINE_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_line_buffer (
        .clock        (clock),
        .reset        (reset),
        .inval_i      (buf_inval),
        .fill_en_i    (fill_en),
        .fill_tag_i   (req_tag_q),
        .fill_data_i  (mem_rdata),
        .lookup_tag_i (if_tag),
        .half_sel_i   (if_addr[HALF_SEL_BIT]),
        .hit_o        (buf_hit),
        .rdata_o      (buf_rdata)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        req_tag_d  = req_tag_q;
        wait_cnt_d = wait_cnt_q;
        fill_en    = 1'b0;
        rsp_ready  = 1'b0;
        rsp_err    = 1'b0;
        rsp_data   = '0;

        case (state_q)
            IDLE: begin
                if (if_valid) begin
                    if (misaligned) begin
                        rsp_ready = 1'b1;
                        rsp_err   = 1'b1;
                        rsp_data  = ERR_INST;
                    end else if (buf_hit) begin
                        rsp_ready = 1'b1;
                        rsp_data  = buf_rdata;
                    end else begin
                        state_d    = REQ;
                        req_tag_d  = if_tag;
                        wait_cnt_d = '0;
                    end
                end
            end

            REQ: begin
                if (wait_cnt_q != CNT_LAST) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (mem_ack) begin
                    // A flush racing the ack discards the now-stale line.
                    fill_en = !flush;
                    state_d = IDLE;
                end else if (timeout) begin
                    rsp_ready = if_valid;
                    rsp_err   = if_valid;
                    rsp_data  = if_valid ? ERR_INST : '0;
                    state_d   = DRAIN;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // The request stays up until the memory answers; its data is dropped.
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            req_tag_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            req_tag_q  <= req_tag_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs are held quiet while reset is asserted, even mid-request.
    assign if_ready     = rsp_ready && !reset;
    assign fetch_err    = rsp_err && !reset;
    assign if_data_read = reset ? '0 : rsp_data;
    assign mem_req      = (state_q != IDLE) && !reset;
    assign mem_addr     = reset ? '0 : {req_tag_q, {LINE_OFF_W{1'b0}}};

endmodule

// File: tb/tb_ysyx_040729_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_ysyx_040729_imem_responder
// Directed vector table, hand-written multi-cycle sequences (flush during a
// miss, reset during a miss) and a randomized phase checked against a
// transaction-level model of the one-line buffer. A latency-programmable
// memory responder answers mem_req.
// ---------------------------------------------------------------------------
module tb_ysyx_040729_imem_responder;

    localparam int unsigned TMO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [63:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data_read;
    logic        fetch_err;
    logic        flush;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int mem_lat = 1;

    always #5 clock = ~clock;

    ysyx_040729_imem_responder #(
        .TIMEOUT (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_addr      (if_addr),
        .if_ready     (if_ready),
        .if_data_read (if_data_read),
        .fetch_err    (fetch_err),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    // Backing memory contents: one fixed line plus an address-derived pattern.
    function automatic logic [63:0] mem_word(input logic [63:0] la);
        if (la == 64'h0000_0000_8000_0000) return 64'h00100093_00000513;
        return {la[31:0] ^ 32'hDEAD_0004, la[31:0] ^ 32'h1234_0000};
    endfunction

    // Memory responder: acks on the mem_lat-th consecutive cycle of mem_req,
    // latency latched when the request first appears.
    initial begin : mem_model
        int cnt;
        int cur_lat;
        cnt     = 0;
        cur_lat = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            #2;
            if (reset || !mem_req) begin
                cnt     = 0;
                mem_ack = 1'b0;
            end else begin
                if (cnt == 0) cur_lat = mem_lat;
                cnt++;
                if (cnt == cur_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                end
            end
            if (!mem_ack) mem_rdata = {$urandom, $urandom};
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One fetch from IDLE-handshake point to its answer. Called at posedge+1;
    // returns at posedge+1 of the cycle after the answer.
    task automatic do_fetch(input logic [63:0] addr, input logic fl, input int lat,
                            input int exp_lat, input logic exp_err,
                            input logic [31:0] exp_data, input int exp_req,
                            input string nm);
        int          cyc;
        int          reqs;
        logic        got;
        logic [63:0] maddr;
        logic        g_err;
        logic [31:0] g_data;
        cyc = 0; reqs = 0; got = 1'b0; maddr = '0; g_err = 1'b0; g_data = '0;
        mem_lat  = lat;
        if_addr  = addr;
        if_valid = 1'b1;
        flush    = fl;
        while (!got && cyc < 40) begin
            @(negedge clock);
            if (mem_req) begin
                if (reqs == 0) maddr = mem_addr;
                reqs++;
            end
            if (if_ready) begin
                got    = 1'b1;
                g_err  = fetch_err;
                g_data = if_data_read;
            end else begin
                @(posedge clock);
                #1;
                flush = 1'b0;
                cyc++;
            end
        end
        @(posedge clock);
        #1;
        flush = 1'b0;
        check({nm, "_answered"}, 64'(got), 64'd1);
        if (got) begin
            check({nm, "_latency"}, 64'(cyc), 64'(exp_lat));
            check({nm, "_err"}, 64'(g_err), 64'(exp_err));
            check({nm, "_data"}, 64'(g_data), 64'(exp_data));
            check({nm, "_req_cycles"}, 64'(reqs), 64'(exp_req));
            if (exp_req > 0) check({nm, "_mem_addr"}, maddr, {addr[63:3], 3'b000});
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        logic        fl;
        int          lat;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_req;
    } vec_t;

    vec_t vecs [14];

    initial begin : main
        logic [10:0] rdy_v;
        logic [10:0] req_v;
        logic [31:0] d10;
        logic        mv;
        logic [60:0] mtag;

        vecs[0]  = '{64'h0000_0000_8000_0000, 1'b0,  3, 4, 1'b0, 32'h0000_0513, 3};
        vecs[1]  = '{64'h0000_0000_8000_0004, 1'b0,  3, 0, 1'b0, 32'h0010_0093, 0};
        vecs[2]  = '{64'h0000_0000_8000_0002, 1'b0,  3, 0, 1'b1, 32'h0000_0000, 0};
        vecs[3]  = '{64'h0000_0000_8000_0000, 1'b0,  3, 0, 1'b0, 32'h0000_0513, 0};
        vecs[4]  = '{64'h0000_0000_8000_0008, 1'b0,  2, 3, 1'b0, 32'h9234_0008, 2};
        vecs[5]  = '{64'h0000_0000_8000_000C, 1'b1,  2, 3, 1'b0, 32'h5EAD_000C, 2};
        vecs[6]  = '{64'h0000_0000_8000_0008, 1'b0,  2, 0, 1'b0, 32'h9234_0008, 0};
        vecs[7]  = '{64'h0000_0000_8000_0001, 1'b0,  2, 0, 1'b1, 32'h0000_0000, 0};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFF8, 1'b0,  1, 2, 1'b0, 32'hEDCB_FFF8, 1};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0,  1, 0, 1'b0, 32'h2152_FFFC, 0};
        vecs[10] = '{64'h0000_0000_FFFF_FFF8, 1'b0,  1, 2, 1'b0, 32'hEDCB_FFF8, 1};
        vecs[11] = '{64'h0000_0000_8000_0004, 1'b0,  3, 4, 1'b0, 32'h0010_0093, 3};
        vecs[12] = '{64'h0000_0000_8000_0010, 1'b0, 12, 8, 1'b1, 32'h0000_0000, 8};
        vecs[13] = '{64'h0000_0000_8000_0010, 1'b0,  2, 7, 1'b0, 32'h9234_0010, 6};

        reset = 1'b1; if_valid = 1'b0; flush = 1'b0; if_addr = '0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_if_ready", 64'(if_ready), 64'd0);
        check("rst_fetch_err", 64'(fetch_err), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_data", 64'(if_data_read), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle_if_ready", 64'(if_ready), 64'd0);
        check("idle_mem_req", 64'(mem_req), 64'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 14; i++) begin
            do_fetch(vecs[i].addr, vecs[i].fl, vecs[i].lat, vecs[i].exp_lat,
                     vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_req,
                     $sformatf("vec%0d", i));
        end

        // Flush in the 2nd REQ cycle, ack in the 4th: no fill, no answer,
        // then a fresh request that completes normally.
        mem_lat = 4; if_addr = 64'h0000_0000_8000_0018; if_valid = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            flush = (c == 2);
            @(negedge clock);
            rdy_v[c] = if_ready;
            req_v[c] = mem_req;
            if (c == 10) d10 = if_data_read;
            @(posedge clock);
            #1;
        end
        flush = 1'b0;
        check("flush_req_ready_seq", 64'(rdy_v), 64'h400);
        check("flush_req_memreq_seq", 64'(req_v), 64'h3DE);
        check("flush_req_data", 64'(d10), 64'h9234_0018);

        // Reset two cycles into a miss; the buffered 0x80000018 line must be gone.
        mem_lat = 5; if_addr = 64'h0000_0000_8000_0020; if_valid = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_mid_req_active", 64'(mem_req), 64'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        do_fetch(64'h0000_0000_8000_0018, 1'b0, 5, 6, 1'b0, 32'h9234_0018, 5, "after_reset");

        // Randomized fetches against a transaction-level buffer model.
        mv   = 1'b1;
        mtag = 61'(64'h0000_0000_8000_0018 >> 3);
        for (int n = 0; n < 80; n++) begin
            logic [63:0] a;
            logic [63:0] line;
            logic [31:0] word;
            logic        fl;
            int          lat;
            a = 64'h0000_0000_8000_0000 + 64'(8 * $urandom_range(0, 3))
                + 64'(4 * $urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 3));
            fl   = ($urandom_range(0, 5) == 0);
            lat  = int'($urandom_range(1, 6));
            line = mem_word({a[63:3], 3'b000});
            word = a[2] ? line[63:32] : line[31:0];
            if (fl) mv = 1'b0;
            if (a[1:0] != 2'b00) begin
                do_fetch(a, fl, lat, 0, 1'b1, 32'h0, 0, $sformatf("rnd%0d", n));
            end else if (mv && mtag == a[63:3]) begin
                do_fetch(a, fl, lat, 0, 1'b0, word, 0, $sformatf("rnd%0d", n));
            end else begin
                do_fetch(a, fl, lat, lat + 1, 1'b0, word, lat, $sformatf("rnd%0d", n));
                mv   = 1'b1;
                mtag = a[63:3];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
